// File: rtl/phase_timer_bank_if.sv
// Control and status bundle for the phase_timer_bank timer channels.
interface phase_timer_bank_if #(
    parameter int NCH   = 4,
    parameter int CNT_W = 8
);
    // Control: tick is a one-cycle global strobe. start and cancel are per-channel
    // one-cycle requests sampled on every rising edge. pause is a level hold.
    // There is no backpressure: the timer accepts every request on the cycle it is seen.
    // Status: expired and any_expired are registered one-cycle pulses.
    // busy and remaining follow the channel registers directly.
    logic                   tick;
    logic [NCH-1:0]         start;
    logic [NCH-1:0]         cancel;
    logic [NCH-1:0]         pause;
    logic [NCH-1:0]         auto_reload;
    logic [NCH*CNT_W-1:0]   load_value;
    logic [NCH-1:0]         expired;
    logic [NCH-1:0]         busy;
    logic [NCH*CNT_W-1:0]   remaining;
    logic                   any_expired;

    modport master (
        output tick, start, cancel, pause, auto_reload, load_value,
        input  expired, busy, remaining, any_expired
    );

    modport slave (
        input  tick, start, cancel, pause, auto_reload, load_value,
        output expired, busy, remaining, any_expired
    );
endinterface

// File: rtl/phase_timer_bank.sv
// Bank of independent down-counting timers sharing one tick strobe.
// Each channel runs an IDLE/RUN/HOLD FSM with one-shot or periodic reload.
module phase_timer_bank #(
    parameter int NCH   = 4,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    phase_timer_bank_if.slave  tmr,
    output logic [2*NCH-1:0]   dbg_state_o
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    state_e           state_q    [NCH];
    state_e           state_d    [NCH];
    logic [CNT_W-1:0] count_q    [NCH];
    logic [CNT_W-1:0] count_d    [NCH];
    logic [CNT_W-1:0] reload_q   [NCH];
    logic [CNT_W-1:0] reload_d   [NCH];
    logic [NCH-1:0]   periodic_q;
    logic [NCH-1:0]   periodic_d;
    logic [NCH-1:0]   expired_q;
    logic [NCH-1:0]   expired_d;
    logic             any_expired_q;

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            state_d[i]    = state_q[i];
            count_d[i]    = count_q[i];
            reload_d[i]   = reload_q[i];
            periodic_d[i] = periodic_q[i];
            expired_d[i]  = 1'b0;
            if (tmr.cancel[i]) begin
                state_d[i] = ST_IDLE;
                count_d[i] = '0;
            end else if (tmr.start[i]) begin
                // A zero load is an immediate expiry; the channel never becomes busy.
                if (tmr.load_value[i*CNT_W +: CNT_W] == '0) begin
                    expired_d[i] = 1'b1;
                    state_d[i]   = ST_IDLE;
                    count_d[i]   = '0;
                end else begin
                    count_d[i]    = tmr.load_value[i*CNT_W +: CNT_W];
                    reload_d[i]   = tmr.load_value[i*CNT_W +: CNT_W];
                    periodic_d[i] = tmr.auto_reload[i];
                    state_d[i]    = ST_RUN;
                end
            end else begin
                case (state_q[i])
                    ST_RUN: begin
                        if (tmr.pause[i]) begin
                            state_d[i] = ST_HOLD;
                        end else if (tmr.tick) begin
                            if (count_q[i] == CNT_W'(1)) begin
                                expired_d[i] = 1'b1;
                                if (periodic_q[i]) begin
                                    count_d[i] = reload_q[i];
                                end else begin
                                    count_d[i] = '0;
                                    state_d[i] = ST_IDLE;
                                end
                            end else begin
                                count_d[i] = count_q[i] - CNT_W'(1);
                            end
                        end
                    end
                    // Leaving HOLD costs one cycle; a tick seen here is not counted.
                    ST_HOLD: begin
                        if (!tmr.pause[i]) begin
                            state_d[i] = ST_RUN;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i]  <= ST_IDLE;
                count_q[i]  <= '0;
                reload_q[i] <= '0;
            end
            periodic_q    <= '0;
            expired_q     <= '0;
            any_expired_q <= 1'b0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                state_q[i]  <= state_d[i];
                count_q[i]  <= count_d[i];
                reload_q[i] <= reload_d[i];
            end
            periodic_q    <= periodic_d;
            expired_q     <= expired_d;
            any_expired_q <= |expired_d;
        end
    end

    always_comb begin
        tmr.busy      = '0;
        tmr.remaining = '0;
        dbg_state_o   = '0;
        for (int i = 0; i < NCH; i++) begin
            tmr.busy[i]                      = (state_q[i] != ST_IDLE);
            tmr.remaining[i*CNT_W +: CNT_W]  = count_q[i];
            dbg_state_o[2*i +: 2]            = state_q[i];
        end
    end

    assign tmr.expired     = expired_q;
    assign tmr.any_expired = any_expired_q;
endmodule

// File: tb/tb_phase_timer_bank.sv
// Directed bench for phase_timer_bank: rule-level channel model checked every cycle,
// plus hand-computed expectations at the interesting points of each scenario.
module tb_phase_timer_bank;
    localparam int NCH   = 4;
    localparam int CNT_W = 8;

    logic             clk;
    logic             reset;
    logic [2*NCH-1:0] dbg_state;

    phase_timer_bank_if #(.NCH(NCH), .CNT_W(CNT_W)) tmr_if ();

    phase_timer_bank #(.NCH(NCH), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .reset       (reset),
        .tmr         (tmr_if),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // ---------------- behavioural model ----------------
    // A channel is "active" while counting toward expiry and "frozen" while held.
    int             m_cnt [NCH];
    int             m_rel [NCH];
    bit             m_per [NCH];
    bit             m_act [NCH];
    bit             m_frz [NCH];
    logic [NCH-1:0] exp_q [$];

    initial begin
        for (int i = 0; i < NCH; i++) begin
            m_cnt[i] = 0; m_rel[i] = 0; m_per[i] = 0; m_act[i] = 0; m_frz[i] = 0;
        end
    end

    always @(posedge clk) begin
        logic [NCH-1:0] ev;
        int nc, nr, lv;
        bit na, nf, np;
        ev = '0;
        for (int i = 0; i < NCH; i++) begin
            nc = m_cnt[i]; nr = m_rel[i]; na = m_act[i]; nf = m_frz[i]; np = m_per[i];
            lv = int'(tmr_if.load_value[i*CNT_W +: CNT_W]);
            if (reset) begin
                nc = 0; nr = 0; na = 0; nf = 0; np = 0;
            end else if (tmr_if.cancel[i]) begin
                nc = 0; na = 0; nf = 0;
            end else if (tmr_if.start[i]) begin
                if (lv == 0) begin
                    ev[i] = 1'b1; nc = 0; na = 0; nf = 0;
                end else begin
                    nc = lv; nr = lv; np = tmr_if.auto_reload[i]; na = 1; nf = 0;
                end
            end else if (na && nf) begin
                if (!tmr_if.pause[i]) nf = 0;
            end else if (na) begin
                if (tmr_if.pause[i]) begin
                    nf = 1;
                end else if (tmr_if.tick) begin
                    if (nc == 1) begin
                        ev[i] = 1'b1;
                        if (np) nc = nr;
                        else begin nc = 0; na = 0; end
                    end else begin
                        nc = nc - 1;
                    end
                end
            end
            m_cnt[i] <= nc; m_rel[i] <= nr; m_act[i] <= na; m_frz[i] <= nf; m_per[i] <= np;
        end
        exp_q.push_back(ev);
    end

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        logic [NCH-1:0]       e_exp;
        logic [NCH-1:0]       e_busy;
        logic [NCH*CNT_W-1:0] e_rem;
        if (exp_q.size() == 0) begin
            chk("model_queue_empty", 32'd0, 32'd1);
        end else begin
            e_exp = exp_q.pop_front();
            e_busy = '0;
            e_rem  = '0;
            for (int i = 0; i < NCH; i++) begin
                e_busy[i] = m_act[i];
                e_rem[i*CNT_W +: CNT_W] = CNT_W'(m_cnt[i]);
            end
            chk("model_expired", 32'(tmr_if.expired), 32'(e_exp));
            chk("model_any_expired", 32'(tmr_if.any_expired), 32'(|e_exp));
            chk("model_busy", 32'(tmr_if.busy), 32'(e_busy));
            chk("model_remaining", 32'(tmr_if.remaining), 32'(e_rem));
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic set_lv(input int ch, input int v);
        tmr_if.load_value[ch*CNT_W +: CNT_W] = CNT_W'(v);
    endtask

    function automatic logic [CNT_W-1:0] rem(input int ch);
        return tmr_if.remaining[ch*CNT_W +: CNT_W];
    endfunction

    // ---------------- directed stimulus ----------------
    initial begin
        int n;
        reset = 1'b1;
        tmr_if.tick = 1'b0;
        tmr_if.start = '0;
        tmr_if.cancel = '0;
        tmr_if.pause = '0;
        tmr_if.auto_reload = '0;
        tmr_if.load_value = '0;
        repeat (2) cyc();
        chk("reset_expired", 32'(tmr_if.expired), 32'd0);
        chk("reset_busy", 32'(tmr_if.busy), 32'd0);
        chk("reset_remaining", 32'(tmr_if.remaining), 32'd0);
        chk("reset_any", 32'(tmr_if.any_expired), 32'd0);
        chk("reset_dbg_state", 32'(dbg_state), 32'd0);

        // One-shot N=3 on ch0, tick every cycle
        reset = 1'b0;
        tmr_if.tick = 1'b1;
        set_lv(0, 3);
        tmr_if.start = 4'b0001;
        cyc();
        tmr_if.start = '0;
        chk("os_rem_3", 32'(rem(0)), 32'd3);
        chk("os_busy", 32'(tmr_if.busy[0]), 32'd1);
        cyc(); chk("os_rem_2", 32'(rem(0)), 32'd2);
        cyc(); chk("os_rem_1", 32'(rem(0)), 32'd1);
        chk("os_no_early_exp", 32'(tmr_if.expired), 32'd0);
        cyc();
        chk("os_rem_0", 32'(rem(0)), 32'd0);
        chk("os_expired", 32'(tmr_if.expired), 32'b0001);
        chk("os_busy_fall", 32'(tmr_if.busy[0]), 32'd0);
        cyc();
        chk("os_single_pulse", 32'(tmr_if.expired), 32'd0);

        // Periodic N=2 on ch1, tick every 2nd cycle
        tmr_if.tick = 1'b0;
        set_lv(1, 2);
        tmr_if.auto_reload = 4'b0010;
        tmr_if.start = 4'b0010;
        cyc();
        tmr_if.start = '0;
        tmr_if.auto_reload = '0;
        chk("per_rem_load", 32'(rem(1)), 32'd2);
        for (int k = 0; k < 16; k++) begin
            tmr_if.tick = (k % 2 == 0);
            cyc();
            chk("per_expired", 32'(tmr_if.expired[1]), 32'((k % 4) == 2));
            chk("per_rem", 32'(rem(1)), ((k % 4) < 2) ? 32'd1 : 32'd2);
        end
        tmr_if.tick = 1'b0;
        tmr_if.cancel = 4'b0010;
        cyc();
        tmr_if.cancel = '0;
        chk("cancel_busy", 32'(tmr_if.busy[1]), 32'd0);
        chk("cancel_rem", 32'(rem(1)), 32'd0);

        // Zero load on ch2
        set_lv(2, 0);
        tmr_if.start = 4'b0100;
        cyc();
        tmr_if.start = '0;
        chk("zero_expired", 32'(tmr_if.expired), 32'b0100);
        chk("zero_any", 32'(tmr_if.any_expired), 32'd1);
        chk("zero_busy", 32'(tmr_if.busy[2]), 32'd0);
        cyc();
        chk("zero_pulse_end", 32'(tmr_if.expired), 32'd0);

        // Pause on ch3, N=5, tick every cycle
        tmr_if.tick = 1'b1;
        set_lv(3, 5);
        tmr_if.start = 4'b1000;
        cyc();
        tmr_if.start = '0;
        chk("pause_rem_5", 32'(rem(3)), 32'd5);
        cyc(); chk("pause_rem_4", 32'(rem(3)), 32'd4);
        cyc(); chk("pause_rem_3", 32'(rem(3)), 32'd3);
        tmr_if.pause = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("pause_frozen", 32'(rem(3)), 32'd3);
            chk("pause_busy", 32'(tmr_if.busy[3]), 32'd1);
        end
        tmr_if.pause = '0;
        cyc();
        chk("pause_resume_no_tick", 32'(rem(3)), 32'd3);
        n = 0;
        while (!tmr_if.expired[3] && n < 20) begin
            cyc();
            n++;
        end
        chk("pause_expiry_delay", 32'(n), 32'd3);
        tmr_if.tick = 1'b0;
        cyc();

        // All channels N=1 together, then one tick
        for (int i = 0; i < NCH; i++) set_lv(i, 1);
        tmr_if.start = 4'b1111;
        cyc();
        tmr_if.start = '0;
        chk("all_busy", 32'(tmr_if.busy), 32'b1111);
        tmr_if.tick = 1'b1;
        cyc();
        tmr_if.tick = 1'b0;
        chk("all_expired", 32'(tmr_if.expired), 32'b1111);
        chk("all_any", 32'(tmr_if.any_expired), 32'd1);
        cyc();
        chk("all_any_single", 32'(tmr_if.any_expired), 32'd0);

        // Same again, with cancel on ch0 and restart on ch1 in the tick cycle
        tmr_if.start = 4'b1111;
        cyc();
        tmr_if.tick = 1'b1;
        tmr_if.cancel = 4'b0001;
        tmr_if.start = 4'b0010;
        set_lv(1, 3);
        cyc();
        tmr_if.tick = 1'b0;
        tmr_if.cancel = '0;
        tmr_if.start = '0;
        chk("mix_expired", 32'(tmr_if.expired), 32'b1100);
        chk("mix_any", 32'(tmr_if.any_expired), 32'd1);
        chk("mix_busy", 32'(tmr_if.busy), 32'b0010);
        chk("mix_rem1", 32'(rem(1)), 32'd3);
        chk("mix_rem0", 32'(rem(0)), 32'd0);
        tmr_if.cancel = 4'b0010;
        cyc();
        tmr_if.cancel = '0;

        // Reset colliding with an expiry on ch0
        tmr_if.tick = 1'b1;
        set_lv(0, 4);
        tmr_if.start = 4'b0001;
        cyc();
        tmr_if.start = '0;
        repeat (3) cyc();
        chk("rst_pre_rem1", 32'(rem(0)), 32'd1);
        reset = 1'b1;
        cyc();
        chk("rst_no_expired", 32'(tmr_if.expired), 32'd0);
        chk("rst_no_any", 32'(tmr_if.any_expired), 32'd0);
        chk("rst_busy0", 32'(tmr_if.busy), 32'd0);
        chk("rst_rem0", 32'(tmr_if.remaining), 32'd0);

        // First start accepted right after reset deasserts
        reset = 1'b0;
        tmr_if.tick = 1'b0;
        set_lv(0, 2);
        tmr_if.start = 4'b0001;
        cyc();
        tmr_if.start = '0;
        chk("post_rst_start_rem", 32'(rem(0)), 32'd2);
        chk("post_rst_start_busy", 32'(tmr_if.busy[0]), 32'd1);
        repeat (3) cyc();
        chk("post_rst_idle_hold", 32'(rem(0)), 32'd2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
